// File: rtl/unified_mem.sv
// Unified instruction/data store: registered fetch port with stall hold, plus a data port
// with sized loads/stores and misalignment detection. Define MEM_CLEAR_EN to zero the array after reset.
module unified_mem #(
   parameter int          XLEN  = 32,
   parameter int          DEPTH = 1024,
   parameter logic [31:0] NOP   = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   output logic [XLEN-1:0] ir,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [1:0]      d_size,
   input  logic            d_unsigned,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic            d_ready,
   output logic            d_rvalid,
   output logic [XLEN-1:0] mdr,
   output logic            d_err
);
   localparam int NB  = XLEN / 8;
   localparam int OFF = $clog2(NB);
   localparam int AW  = $clog2(DEPTH);

   typedef struct packed {
      logic            vld;
      logic            err;
      logic [XLEN-1:0] data;
   } rsp_t;

   logic [XLEN-1:0] mem [DEPTH];
   logic [AW-1:0]   fidx, didx, clr_cnt;
   logic [OFF-1:0]  off;
   logic            clearing, acc, mis, st_en;
   logic [7:0]      bm;
   logic [15:0]     be16;
   logic [NB-1:0]   be;
   logic [XLEN-1:0] wsh, rsh, msk, ld;
   logic            sb;
   rsp_t            rsp;
   logic            unused;

   assign fidx   = i_addr[OFF +: AW];
   assign didx   = d_addr[OFF +: AW];
   assign off    = d_addr[OFF-1:0];
   assign unused = &{1'b0, i_addr, d_addr};

`ifdef MEM_CLEAR_EN
   typedef enum logic {RUN, CLEAR} state_t;
   state_t state, state_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_cnt == AW'(DEPTH - 1)) state_nxt = RUN;
         default: state_nxt = state;
      endcase
   end

   assign clearing = (state == CLEAR);
`else
   assign clearing = 1'b0;
   assign clr_cnt  = '0;
`endif

   assign d_ready = ~rst & ~clearing;
   assign acc     = d_req & d_ready;

   always_comb begin
      mis = 1'b0;
      bm  = 8'h01;
      case (d_size)
         2'd1: begin mis = d_addr[0];                      bm = 8'h03; end
         2'd2: begin mis = |d_addr[1:0];                   bm = 8'h0F; end
         2'd3: begin mis = (XLEN == 32) || |d_addr[2:0];   bm = 8'hFF; end
         default: ;
      endcase
   end

   // Lane enables and write data are both positioned by the in-word byte offset
   assign be16  = {8'h00, bm} << off;
   assign be    = be16[NB-1:0];
   assign wsh   = d_wdata << {off, 3'b000};
   assign st_en = acc & d_we & ~mis;

   always_ff @(posedge clk) begin
      if (clearing) begin
         mem[clr_cnt] <= '0;
      end else if (st_en) begin
         for (int b = 0; b < NB; b++)
            if (be[b]) mem[didx][8*b +: 8] <= wsh[8*b +: 8];
      end
   end

   assign rsh = mem[didx] >> {off, 3'b000};

   always_comb begin
      msk = '1;
      sb  = rsh[XLEN-1];
      case (d_size)
         2'd0: begin msk = XLEN'(8'hFF);         sb = rsh[7];  end
         2'd1: begin msk = XLEN'(16'hFFFF);      sb = rsh[15]; end
         2'd2: begin msk = XLEN'(32'hFFFF_FFFF); sb = rsh[31]; end
         default: ;
      endcase
      ld = (rsh & msk) | ((~d_unsigned & sb) ? ~msk : '0);
   end

   // Reads sample the array before this edge's store lands: fetch is read-first
   always_ff @(posedge clk) begin
      if (rst) begin
         ir  <= XLEN'(NOP);
         rsp <= '0;
      end else begin
         if (i_req) ir <= clearing ? '0 : mem[fidx];
         rsp.vld  <= acc;
         rsp.err  <= acc & mis;
         rsp.data <= (acc & ~d_we & ~mis) ? ld : '0;
      end
   end

   assign d_rvalid = rsp.vld;
   assign d_err    = rsp.err;
   assign mdr      = rsp.data;
endmodule

// File: tb/tb_unified_mem.sv
// Directed bench for unified_mem (default build, XLEN=32, DEPTH=1024).
module tb_unified_mem;
   logic        clk = 1'b0;
   logic        rst, i_req, d_req, d_we, d_unsigned;
   logic [1:0]  d_size;
   logic [31:0] i_addr, d_addr, d_wdata, ir, mdr;
   logic        d_ready, d_rvalid, d_err;
   int          checks = 0;
   int          errors = 0;

   unified_mem #(.XLEN(32), .DEPTH(1024), .NOP(32'h0000_0013)) dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .ir(ir),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rvalid(d_rvalid),
      .mdr(mdr), .d_err(d_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic dr(input logic we, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd);
      d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = u; d_addr = a; d_wdata = wd;
   endtask

   task automatic idle();
      d_req = 1'b0; d_we = 1'b0;
   endtask

   task automatic rsp(input string tag, input logic [31:0] data, input logic err);
      chk({tag, ".rvalid"}, {31'b0, d_rvalid}, 32'd1);
      chk({tag, ".err"},    {31'b0, d_err},    {31'b0, err});
      chk({tag, ".mdr"},    mdr,               data);
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
      tick(); tick();
      chk("rst.ir", ir, 32'h0000_0013);
      chk("rst.mdr", mdr, 32'h0);
      chk("rst.rvalid", {31'b0, d_rvalid}, 32'd0);
      chk("rst.err", {31'b0, d_err}, 32'd0);
      chk("rst.ready", {31'b0, d_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", {31'b0, d_ready}, 32'd1);

      dr(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF);           tick(); rsp("st_w10", 32'h0, 0);
      dr(0, 2'd0, 0, 32'h13, 32'h0);                   tick(); rsp("lb_13", 32'hFFFF_FFDE, 0);
      dr(0, 2'd1, 1, 32'h10, 32'h0);                   tick(); rsp("lhu_10", 32'h0000_BEEF, 0);
      dr(1, 2'd0, 0, 32'h11, 32'hFFFF_FF5A);           tick(); rsp("st_b11", 32'h0, 0);
      dr(0, 2'd2, 0, 32'h10, 32'h0);                   tick(); rsp("lw_10", 32'hDEAD_5AEF, 0);
      dr(0, 2'd1, 0, 32'h12, 32'h0);                   tick(); rsp("lh_12", 32'hFFFF_DEAD, 0);
      dr(0, 2'd0, 1, 32'h11, 32'h0);                   tick(); rsp("lbu_11", 32'h0000_005A, 0);
      dr(1, 2'd2, 0, 32'h12, 32'h0);                   tick(); rsp("st_w12_mis", 32'h0, 1);
      dr(0, 2'd2, 0, 32'h10, 32'h0);                   tick(); rsp("lw_10_kept", 32'hDEAD_5AEF, 0);
      dr(0, 2'd1, 0, 32'h11, 32'h0);                   tick(); rsp("lh_11_mis", 32'h0, 1);
      dr(0, 2'd3, 0, 32'h10, 32'h0);                   tick(); rsp("ld_size3", 32'h0, 1);

      // fetch/store collision on the same word
      dr(1, 2'd2, 0, 32'h20, 32'hCAFE_F00D);           tick(); rsp("st_w20", 32'h0, 0);
      i_req = 1'b1; i_addr = 32'h22;
      dr(1, 2'd2, 0, 32'h20, 32'h1234_5678);           tick();
      chk("fetch_read_first", ir, 32'hCAFE_F00D);
      dr(0, 2'd2, 0, 32'h20, 32'h0);                   tick();
      chk("fetch_new", ir, 32'h1234_5678);
      rsp("lw_after_st", 32'h1234_5678, 0);
      i_req = 1'b0; i_addr = 32'h10;
      dr(1, 2'd1, 0, 32'h22, 32'h0000_8001);           tick();
      chk("fetch_hold", ir, 32'h1234_5678);
      dr(0, 2'd1, 0, 32'h22, 32'h0);                   tick(); rsp("lh_22", 32'hFFFF_8001, 0);
      dr(0, 2'd2, 0, 32'h20, 32'h0);                   tick(); rsp("lw_20", 32'h8001_5678, 0);
      chk("fetch_hold2", ir, 32'h1234_5678);

      // address wrap modulo DEPTH words
      dr(1, 2'd2, 0, 32'h1004, 32'hA5A5_5A5A);         tick(); rsp("st_1004", 32'h0, 0);
      dr(0, 2'd2, 0, 32'h0004, 32'h0);                 tick(); rsp("lw_0004", 32'hA5A5_5A5A, 0);
      idle();                                          tick();
      chk("rvalid_pulse", {31'b0, d_rvalid}, 32'd0);

      // request coinciding with reset is dropped
      dr(1, 2'd2, 0, 32'h4, 32'h0);
      rst = 1'b1;                                      tick();
      chk("rst_req.rvalid", {31'b0, d_rvalid}, 32'd0);
      chk("rst_req.ir", ir, 32'h0000_0013);
      rst = 1'b0; idle();                              tick();
      chk("rst_req.no_rvalid", {31'b0, d_rvalid}, 32'd0);
      dr(0, 2'd2, 0, 32'h4, 32'h0);                    tick(); rsp("lw_4_kept", 32'hA5A5_5A5A, 0);
      dr(0, 2'd2, 0, 32'h10, 32'h0);                   tick(); rsp("lw_10_retained", 32'hDEAD_5AEF, 0);
      idle();                                          tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
